// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the serial add/sub block.
package add_sub_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2, used to size the digit index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned n;
    int unsigned p;
    n = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module add_sub_digit
  import add_sub_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  // Bitwise ripple of sum and carry across the digit.
  always_comb begin
    s      = '0;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? clog2(NDIG) : 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("add_sub_serial: WIDTH must be at least 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_chk_digit
    $error("add_sub_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sub;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_acc;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_res;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  logic [DIGIT-1:0]  w_s;
  logic              w_cout;
  logic              w_c_msb;
  logic [WIDTH-1:0]  w_acc_next;
  logic              w_last;

  // Operands shift right one digit per cycle, so the adder always sees digit 0.
  add_sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (r_a[DIGIT-1:0]),
    .y    (r_b[DIGIT-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c_msb(w_c_msb)
  );

  // Sum digits enter the accumulator from the top; after NDIG steps digit i sits at position i.
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
  assign w_last     = (r_idx == IDXW'(NDIG - 1));

  // Control FSM, working datapath and the held result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_cout;
          r_acc   <= w_acc_next;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
            r_res   <= w_acc_next;
            r_cout  <= w_cout ^ r_sub;
            r_ovf   <= w_c_msb ^ w_cout;
            r_zero  <= (w_acc_next == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign r    = r_res;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
